// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: the serial line, the byte handshake and the status outputs.
// The master modport is the line driver/consumer side; the slave modport is the receiver.
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rx,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a per-frame bit-timing counter that is restarted on every start edge,
// so each bit is sampled near its middle. Bytes leave through a valid/ack handshake.
module uart_rx #(
  parameter int unsigned CLK_DIV = 1250
) (
  input  logic     clk,
  input  logic     nrst,
  uart_rx_if.slave bus
);

  localparam int unsigned HALF_DIV  = CLK_DIV / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        busy_q;
  logic        sync1_q, sync2_q;
  logic        rx_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame state, timing counter, shift register and the registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (valid_q && bus.rx_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = 16'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            // A same-cycle ack consumes the old byte, so the overwrite is not an overrun.
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~bus.rx_ack;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=16: each test task drives frames bit by bit
// and checks the handshake and error flags against hand-computed values.
module tb_uart_rx;

  localparam int BIT_CYC = 16;

  logic clk;
  logic nrst;
  int   n_vec = 0;
  int   n_err = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   load_cnt = 0;
  logic prev_valid = 1'b0;

  uart_rx_if bus();

  uart_rx #(.CLK_DIV(16)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters for one-cycle pulses and rx_valid rising edges.
  always @(negedge clk) begin
    prev_valid <= bus.rx_valid;
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (bus.rx_valid && !prev_valid) load_cnt <= load_cnt + 1;
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
    n_vec++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", bus.rx_data); end
    n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", bus.overrun); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    nrst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_byte;
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    n_vec++; if (bus.rx_valid !== 1'b1) begin n_err++; $display("FAIL a5_valid got=%b exp=1", bus.rx_valid); end
    n_vec++; if (bus.rx_data !== 8'hA5) begin n_err++; $display("FAIL a5_data got=%h exp=a5", bus.rx_data); end
    n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0); end
    n_vec++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL a5_ovr got=%0d exp=0", ovr_cnt - o0); end
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL a5_ack got=%b exp=0", bus.rx_valid); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch;
    int l0;
    l0 = load_cnt;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_hi got=%b exp=1", bus.busy); end
    repeat (11) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_lo got=%b exp=0", bus.busy); end
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", bus.rx_valid); end
    n_vec++; if (load_cnt - l0 !== 0) begin n_err++; $display("FAIL glitch_loads got=%0d exp=0", load_cnt - l0); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_err;
    int f0, l0;
    f0 = ferr_cnt; l0 = load_cnt;
    send_frame(8'h3C, 1'b0);
    bus.rx = 1'b0;
    repeat (100) @(negedge clk);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid got=%b exp=0", bus.rx_valid); end
    n_vec++; if (bus.rx_data !== 8'hA5) begin n_err++; $display("FAIL ferr_data got=%h exp=a5", bus.rx_data); end
    n_vec++; if (load_cnt - l0 !== 0) begin n_err++; $display("FAIL ferr_loads got=%0d exp=0", load_cnt - l0); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy got=%b exp=1", bus.busy); end
    bus.rx = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle_busy got=%b exp=0", bus.busy); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    n_vec++; if (bus.rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_first_data got=%h exp=11", bus.rx_data); end
    n_vec++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL ovr_first_pulses got=%0d exp=0", ovr_cnt - o0); end
    send_frame(8'h22, 1'b1);
    n_vec++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
    n_vec++; if (bus.rx_data !== 8'h22) begin n_err++; $display("FAIL ovr_data got=%h exp=22", bus.rx_data); end
    n_vec++; if (bus.rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b exp=1", bus.rx_valid); end
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack got=%b exp=0", bus.rx_valid); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int f0, o0, l0;
    logic [7:0] got [2];
    f0 = ferr_cnt; o0 = ovr_cnt; l0 = load_cnt;
    got[0] = 8'h5A; got[1] = 8'h5A;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int w;
          w = 0;
          while (!bus.rx_valid && w < 400) begin
            @(negedge clk);
            w++;
          end
          if (w >= 400) begin
            n_vec++; n_err++;
            $display("FAIL b2b_timeout byte=%0d got=no_valid exp=valid", k);
          end else begin
            got[k] = bus.rx_data;
            bus.rx_ack = 1'b1;
            @(negedge clk);
            bus.rx_ack = 1'b0;
          end
        end
      end
    join
    repeat (2) @(negedge clk);
    n_vec++; if (got[0] !== 8'h00) begin n_err++; $display("FAIL b2b_first got=%h exp=00", got[0]); end
    n_vec++; if (got[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_second got=%h exp=ff", got[1]); end
    n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    n_vec++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL b2b_ovr got=%0d exp=0", ovr_cnt - o0); end
    n_vec++; if (load_cnt - l0 !== 2) begin n_err++; $display("FAIL b2b_loads got=%0d exp=2", load_cnt - l0); end
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid got=%b exp=0", bus.rx_valid); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    bus.rx = d[4];
    repeat (8) @(negedge clk);
    nrst = 1'b0;
    #1;
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got=%b exp=0", bus.rx_valid); end
    n_vec++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data got=%h exp=00", bus.rx_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_ferr got=%b exp=0", bus.frame_err); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovr got=%b exp=0", bus.overrun); end
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_nopartial got=%b exp=0", bus.rx_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle got=%b exp=0", bus.busy); end
    send_frame(8'hC3, 1'b1);
    n_vec++; if (bus.rx_valid !== 1'b1) begin n_err++; $display("FAIL c3_valid got=%b exp=1", bus.rx_valid); end
    n_vec++; if (bus.rx_data !== 8'hC3) begin n_err++; $display("FAIL c3_data got=%h exp=c3", bus.rx_data); end
  endtask

  initial begin
    nrst       = 1'b0;
    bus.rx     = 1'b1;
    bus.rx_ack = 1'b0;
    test_reset();
    test_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
